writeback_queue: RTL
====================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter: DEPTH, 2, number of entries in the load-result FIFO (power of two, 2..8).
REQ-002 Ports SHALL be exactly:
- clock_i  in  1  sole clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- alu_valid_i  in  1  ALU result present this cycle; always accepted, no backpressure.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  32  ALU result.
- ld_valid_i  in  1  load result offered.
- ld_ready_o  out  1  load result accepted when ld_valid_i && ld_ready_o.
- ld_rd_i  in  5  load destination register.
- ld_data_i  in  32  load result.
- reg_write_o  out  1  register-file write enable.
- wr_register_o  out  5  register-file write address.
- wr_data_o  out  32  register-file write data.
- rd_register_1_i, rd_register_2_i  in  5 each  forwarding lookup addresses.
- fwd_hit_1_o, fwd_hit_2_o  out  1 each  lookup matches a pending write.
- fwd_data_1_o, fwd_data_2_o  out  32 each  data of the matching pending write.
- empty_o  out  1  no pending writes anywhere in the block.

Function
REQ-003 The block SHALL drive the register-file write port at most once per cycle; reg_write_o, wr_register_o, wr_data_o SHALL be registered (output stage).
REQ-004 Per cycle, the issue source SHALL be selected in priority order: (a) ALU if alu_valid_i && alu_rd_i != 0; (b) FIFO head if FIFO non-empty; (c) a load accepted this cycle if FIFO empty; (d) none.
REQ-005 The selected source SHALL appear on the write port the following cycle (latency 1); with no source, reg_write_o SHALL be 0 the following cycle.
REQ-006 An accepted load not issued in its acceptance cycle SHALL be pushed into the FIFO; FIFO order SHALL be preserved.
REQ-007 ld_ready_o SHALL be 1 iff reset_i is 0 and FIFO occupancy < DEPTH, or occupancy == DEPTH and the head pops this cycle (i.e. no ALU issue).
REQ-008 Writes to x0 (rd == 0) from either source SHALL be discarded: ALU not issued; load accepted but neither pushed nor issued.
REQ-009 Each FIFO entry SHALL carry a valid bit; an ALU issue whose alu_rd_i matches a valid FIFO entry SHALL clear that entry's valid bit (ALU is younger by pipeline contract).
REQ-010 A load accepted in the same cycle as an ALU issue to the same rd SHALL be discarded (load is older).
REQ-011 Popping an invalidated FIFO entry SHALL consume the cycle's FIFO slot and produce reg_write_o = 0 the following cycle.
REQ-012 Invariant: at most one pending write (output stage plus valid FIFO entries) per nonzero rd.
REQ-013 fwd_hit_n_o SHALL be combinational: 1 iff rd_register_n_i != 0 and matches the output stage (reg_write_o = 1) or a valid FIFO entry; fwd_data_n_o SHALL be that entry's data, else 0.
REQ-014 empty_o SHALL be 1 iff FIFO occupancy is 0 and reg_write_o is 0.
REQ-015 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter SHALL range 0..DEPTH and never overflow or underflow.

Reset
REQ-016 While reset_i = 1 at a rising edge: FIFO occupancy, pointers and valid bits SHALL clear; reg_write_o, wr_register_o, wr_data_o SHALL become 0.
REQ-017 While reset_i = 1, ld_ready_o SHALL be 0 and no load or ALU result SHALL be accepted; results in flight are lost.
REQ-018 After reset: empty_o = 1, fwd_hit_1_o = fwd_hit_2_o = 0.

Verification
REQ-019 Single load, idle ALU: ld rd=5 data=0x11 -> next cycle reg_write_o=1, wr_register_o=5, wr_data_o=0x11; empty_o=1 one cycle later.
REQ-020 Collision: ALU rd=3 0xA and load rd=4 0xB same cycle -> cycle+1 writes x3=0xA, cycle+2 writes x4=0xB.
REQ-021 Backpressure: ALU valid to distinct nonzero rds every cycle, load offered every cycle -> ld_ready_o drops after DEPTH accepts; ALU stops -> FIFO drains in order, one write per cycle.
REQ-022 Squash: load rd=7 0x1 queued, then ALU rd=7 0x2 -> only x7=0x2 written; queued slot pops with reg_write_o=0.
REQ-023 Forwarding: FIFO holds rd=9 0xCAFE, rd_register_1_i=9, rd_register_2_i=0 -> fwd_hit_1_o=1, fwd_data_1_o=0xCAFE, fwd_hit_2_o=0.
REQ-024 Reset mid-drain: FIFO full, reset_i=1 one cycle -> next cycle reg_write_o=0, empty_o=1, ld_ready_o=1 once reset_i=0.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue
//   Merges two result streams into the single register-file write port.
//   ALU results are always accepted and always take priority; load results
//   are accepted under ready/valid handshaking. Loads that cannot be written
//   in the cycle they arrive wait in a small in-order FIFO. Forwarding
//   lookups search every pending write: the output stage and the valid FIFO
//   entries.
//
// Ports
//   clock_i, reset_i            clock and synchronous active-high reset
//   alu_valid_i/rd_i/data_i     ALU result stream (no backpressure)
//   ld_valid_i/ready_o/rd_i/data_i  load result stream (ready/valid)
//   reg_write_o, wr_register_o, wr_data_o  registered register-file write port
//   rd_register_n_i, fwd_hit_n_o, fwd_data_n_o  two forwarding lookups
//   empty_o                     no pending writes anywhere in the block
module writeback_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [4:0]  ld_rd_i,
  input  logic [31:0] ld_data_i,
  output logic        reg_write_o,
  output logic [4:0]  wr_register_o,
  output logic [31:0] wr_data_o,
  input  logic [4:0]  rd_register_1_i,
  input  logic [4:0]  rd_register_2_i,
  output logic        fwd_hit_1_o,
  output logic        fwd_hit_2_o,
  output logic [31:0] fwd_data_1_o,
  output logic [31:0] fwd_data_2_o,
  output logic        empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [DEPTH-1:0] fifo_valid_q, fifo_valid_d;
  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [4:0]       fifo_rd_d   [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [31:0]      fifo_data_d [DEPTH];

  logic        reg_write_q, reg_write_d;
  logic [4:0]  wr_register_q, wr_register_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic alu_issue;
  logic fifo_empty;
  logic fifo_full;
  logic ld_ready;
  logic ld_accept;
  logic ld_keep;
  logic pop;
  logic push;

  // Handshake and source selection. When the FIFO is full a load can still
  // be taken if the head leaves this cycle, which happens whenever the ALU
  // is not claiming the write port.
  always_comb begin
    alu_issue  = !reset_i && alu_valid_i && (alu_rd_i != 5'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(DEPTH));
    ld_ready   = !reset_i && (!fifo_full || !alu_issue);
    ld_accept  = ld_valid_i && ld_ready;
    // x0 loads and loads overtaken by a same-cycle ALU write to the same rd
    // are accepted but dropped.
    ld_keep    = ld_accept && (ld_rd_i != 5'd0) &&
                 !(alu_issue && (alu_rd_i == ld_rd_i));
    pop        = !reset_i && !alu_issue && !fifo_empty;
    push       = ld_keep && (alu_issue || !fifo_empty);
  end

  // Next-state for the output stage and the FIFO.
  always_comb begin
    reg_write_d   = 1'b0;
    wr_register_d = 5'd0;
    wr_data_d     = 32'd0;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fifo_valid_d  = fifo_valid_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_data_d   = fifo_data_q;

    if (alu_issue) begin
      reg_write_d   = 1'b1;
      wr_register_d = alu_rd_i;
      wr_data_d     = alu_data_i;
    end else if (pop) begin
      // A squashed head still consumes the slot but writes nothing.
      reg_write_d   = fifo_valid_q[head_q];
      wr_register_d = fifo_rd_q[head_q];
      wr_data_d     = fifo_data_q[head_q];
    end else if (ld_keep) begin
      reg_write_d   = 1'b1;
      wr_register_d = ld_rd_i;
      wr_data_d     = ld_data_i;
    end

    // The ALU result is younger than anything queued, so queued writes to
    // the same register become dead.
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_issue && (fifo_rd_q[i] == alu_rd_i)) begin
        fifo_valid_d[i] = 1'b0;
      end
    end

    // Clearing the popped slot keeps stale entries out of forwarding.
    if (pop) begin
      fifo_valid_d[head_q] = 1'b0;
      head_d               = head_q + 1'b1;
    end

    if (push) begin
      fifo_valid_d[tail_q] = 1'b1;
      fifo_rd_d[tail_q]    = ld_rd_i;
      fifo_data_d[tail_q]  = ld_data_i;
      tail_d               = tail_q + 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control state and output stage.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      fifo_valid_q  <= '0;
      reg_write_q   <= 1'b0;
      wr_register_q <= 5'd0;
      wr_data_q     <= 32'd0;
    end else begin
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fifo_valid_q  <= fifo_valid_d;
      reg_write_q   <= reg_write_d;
      wr_register_q <= wr_register_d;
      wr_data_q     <= wr_data_d;
    end
  end

  // Payload storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clock_i) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

  // Forwarding lookups. At most one pending write exists per register, so
  // the order of the searches does not matter.
  always_comb begin
    fwd_hit_1_o  = 1'b0;
    fwd_data_1_o = 32'd0;
    fwd_hit_2_o  = 1'b0;
    fwd_data_2_o = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid_q[i] && (fifo_rd_q[i] == rd_register_1_i)) begin
        fwd_hit_1_o  = 1'b1;
        fwd_data_1_o = fifo_data_q[i];
      end
      if (fifo_valid_q[i] && (fifo_rd_q[i] == rd_register_2_i)) begin
        fwd_hit_2_o  = 1'b1;
        fwd_data_2_o = fifo_data_q[i];
      end
    end
    if (reg_write_q && (wr_register_q == rd_register_1_i)) begin
      fwd_hit_1_o  = 1'b1;
      fwd_data_1_o = wr_data_q;
    end
    if (reg_write_q && (wr_register_q == rd_register_2_i)) begin
      fwd_hit_2_o  = 1'b1;
      fwd_data_2_o = wr_data_q;
    end
    if (rd_register_1_i == 5'd0) begin
      fwd_hit_1_o  = 1'b0;
      fwd_data_1_o = 32'd0;
    end
    if (rd_register_2_i == 5'd0) begin
      fwd_hit_2_o  = 1'b0;
      fwd_data_2_o = 32'd0;
    end
  end

  assign ld_ready_o    = ld_ready;
  assign reg_write_o   = reg_write_q;
  assign wr_register_o = wr_register_q;
  assign wr_data_o     = wr_data_q;
  assign empty_o       = (count_q == '0) && !reg_write_q;

endmodule
